wave_read_scheduler: RTL and testbench
======================================

Name: wave_read_scheduler

Overview:
Controller for the read port of the dual-bank waveform RAM that wave_capture fills. It arbitrates single-sample reads between the display engine (fixed priority, fixed latency) and an auxiliary reader, such as a level meter (req/gnt handshake). It latches the display bank once per frame so a bank swap cannot tear a frame. It generates wave_display_idle, which tells the capture FSM when a bank swap is safe.

Parameters:
ADDR_WIDTH, 12, RAM address width; MSB is the bank bit, lower ADDR_WIDTH-1 bits are the sample index.
DATA_WIDTH, 8, RAM sample width (offset-binary, 128 = midscale).
SAMPLES, 640, valid samples per bank; indices >= SAMPLES are out of range.
RAM_LATENCY, 1, cycles from ram_read_address to ram_read_data (1..4).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
read_index  in  1  bank currently readable (from capture)
frame_start  in  1  one-cycle pulse at start of a display frame
frame_active  in  1  high while the display is in its drawing region
disp_req  in  1  display read request this cycle
disp_index  in  ADDR_WIDTH-1  display sample index
disp_data  out  DATA_WIDTH  display read data
disp_data_valid  out  1  disp_data valid strobe
aux_req  in  1  auxiliary read request (level, held until granted)
aux_index  in  ADDR_WIDTH-1  auxiliary sample index, stable while aux_req is high
aux_gnt  out  1  one-cycle grant pulse
aux_data  out  DATA_WIDTH  auxiliary read data
aux_data_valid  out  1  aux_data valid strobe
ram_read_address  out  ADDR_WIDTH  RAM read address
ram_read_data  in  DATA_WIDTH  RAM read data
wave_display_idle  out  1  high when no frame is using the bank

Behaviour:
- Reset values:
  - state = IDLE, bank latch = 0, ram_read_address = 0.
  - disp_data, aux_data = 0.
  - disp_data_valid, aux_data_valid, aux_gnt = 0.
  - wave_display_idle = 1.
- Bank latch: captures read_index on every frame_start, in any state. Otherwise held. All reads use address {bank, index}.
- Arbitration, evaluated each cycle:
  - disp_req=1: display wins and the address is registered this cycle.
  - Else aux_req=1: aux_gnt pulses this cycle, aux_index is registered as the address, and the aux tag enters the pipeline.
  - Display has absolute priority. Aux may starve while disp_req stays high; this is intended.
  - aux_req held across a grant is treated as a new request on the next cycle.
- Latency: disp_data_valid/aux_data_valid assert exactly 1+RAM_LATENCY cycles after the accepted request.
  - A valid shift register of depth 1+RAM_LATENCY carries {valid, is_aux, oob} per slot.
  - Data is registered into disp_data/aux_data on the valid cycle and held until the next valid.
- Out of range (index >= SAMPLES): the RAM address is still driven. Returned data is forced to 128 (midscale) and valid still strobes.
- FSM:
  - IDLE: wave_display_idle=1. frame_start -> ACTIVE.
  - ACTIVE: wave_display_idle=0. On frame_active falling (registered 1->0 edge), load drain counter with 1+RAM_LATENCY -> DRAIN. frame_start while ACTIVE: relatch bank, stay ACTIVE.
  - DRAIN: wave_display_idle=0. Counter decrements each cycle. At 0 -> IDLE. frame_start in DRAIN -> ACTIVE (relatch bank), counter cleared.
  - Illegal state -> IDLE.
- Simultaneous events:
  - frame_start and a disp_req in the same cycle: the read uses the newly latched bank (latch value bypassed combinationally into the address).
  - Display reads accepted while in IDLE are still served. They do not affect wave_display_idle.
- Reset mid-operation: the in-flight pipeline is flushed with no valid strobes afterwards, and all outputs return to reset values on the next edge.

Optional Feature:
Macro AUX_IDLE_ONLY_EN.
- Defined: aux_gnt is issued only while state == IDLE and disp_req=0. Aux reads therefore never overlap a frame.
- Undefined: aux is granted in any state whenever disp_req=0, as above.

Test Plan:
1. Reset with RAM bank0[5]=0x40, RAM_LATENCY=1, read_index=0, then frame_start followed by disp_req with index 5 -> ram_read_address=0x005, disp_data_valid high 2 cycles later, disp_data=0x40; wave_display_idle drops the cycle after frame_start.
2. Bank latch: read_index=1 at frame_start; read_index toggles to 0 mid-frame; disp index 10 -> address 0x80A for the entire frame. The next frame_start with read_index=0 -> address 0x00A.
3. Contention: disp_req and aux_req both high for 3 cycles, then disp_req low -> aux_gnt pulses only on cycle 4; aux_data_valid follows 2 cycles later; no disp strobes are lost.
4. Drain: frame_active falls with RAM_LATENCY=2 -> wave_display_idle rises exactly 4 cycles after the falling edge (3 drain cycles + IDLE); a frame_start during DRAIN keeps it low.
5. Out of range: disp index 640 and 2047 -> disp_data=0x80 with a valid strobe each time.
6. AUX_IDLE_ONLY_EN defined: aux_req held during ACTIVE with disp_req=0 -> no aux_gnt until wave_display_idle=1, then a grant on that same cycle.

Source files
------------

// File: rtl/wave_read_scheduler.sv
// Read-port scheduler for the dual-bank waveform RAM: display/aux arbitration, per-frame bank
// latch and frame-idle tracking for capture bank swaps. Optional macro: AUX_IDLE_ONLY_EN.
module wave_read_scheduler #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SAMPLES     = 640,
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_index,
  input  logic                  frame_start,
  input  logic                  frame_active,
  input  logic                  disp_req,
  input  logic [ADDR_WIDTH-2:0] disp_index,
  output logic [DATA_WIDTH-1:0] disp_data,
  output logic                  disp_data_valid,
  input  logic                  aux_req,
  input  logic [ADDR_WIDTH-2:0] aux_index,
  output logic                  aux_gnt,
  output logic [DATA_WIDTH-1:0] aux_data,
  output logic                  aux_data_valid,
  output logic [ADDR_WIDTH-1:0] ram_read_address,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  output logic                  wave_display_idle
);

  localparam int unsigned Depth = RAM_LATENCY + 1;
  localparam logic [2:0] DrainLoad = 3'(Depth);
  localparam logic [DATA_WIDTH-1:0] Midscale = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StActive, StDrain} state_e;

  state_e                  state_q;
  logic                    bank_q;
  logic                    frame_active_q;
  logic [2:0]              drain_q;
  logic                    idle_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [Depth-1:0]        pipe_valid_q;
  logic [Depth-1:0]        pipe_aux_q;
  logic [Depth-1:0]        pipe_oob_q;
  logic [DATA_WIDTH-1:0]   disp_hold_q;
  logic [DATA_WIDTH-1:0]   aux_hold_q;

  logic                    bank_eff;
  logic                    aux_take;
  logic                    accept;
  logic [ADDR_WIDTH-2:0]   sel_index;
  logic                    sel_oob;
  logic [DATA_WIDTH-1:0]   ret_data;

  // A frame_start in the same cycle as a read must already steer that read to the new bank.
  assign bank_eff = frame_start ? read_index : bank_q;

`ifdef AUX_IDLE_ONLY_EN
  assign aux_take = ~reset & aux_req & ~disp_req & (state_q == StIdle);
`else
  assign aux_take = ~reset & aux_req & ~disp_req;
`endif

  assign accept    = disp_req | aux_take;
  assign sel_index = disp_req ? disp_index : aux_index;
  assign sel_oob   = 32'(sel_index) >= SAMPLES;
  assign ret_data  = pipe_oob_q[Depth-1] ? Midscale : ram_read_data;

  // The last pipeline slot lines up with ram_read_data; the hold registers keep the last sample.
  assign disp_data_valid   = pipe_valid_q[Depth-1] & ~pipe_aux_q[Depth-1];
  assign aux_data_valid    = pipe_valid_q[Depth-1] & pipe_aux_q[Depth-1];
  assign disp_data         = disp_data_valid ? ret_data : disp_hold_q;
  assign aux_data          = aux_data_valid ? ret_data : aux_hold_q;
  assign aux_gnt           = aux_take;
  assign ram_read_address  = addr_q;
  assign wave_display_idle = idle_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      bank_q         <= 1'b0;
      frame_active_q <= 1'b0;
      drain_q        <= 3'd0;
      idle_q         <= 1'b1;
      addr_q         <= '0;
      pipe_valid_q   <= '0;
      pipe_aux_q     <= '0;
      pipe_oob_q     <= '0;
      disp_hold_q    <= '0;
      aux_hold_q     <= '0;
    end else begin
      frame_active_q <= frame_active;
      if (frame_start) begin
        bank_q <= read_index;
      end
      if (accept) begin
        addr_q <= {bank_eff, sel_index};
      end
      pipe_valid_q <= {pipe_valid_q[Depth-2:0], accept};
      pipe_aux_q   <= {pipe_aux_q[Depth-2:0], aux_take};
      pipe_oob_q   <= {pipe_oob_q[Depth-2:0], sel_oob};
      if (disp_data_valid) begin
        disp_hold_q <= ret_data;
      end
      if (aux_data_valid) begin
        aux_hold_q <= ret_data;
      end

      case (state_q)
        StIdle: begin
          if (frame_start) begin
            state_q <= StActive;
            idle_q  <= 1'b0;
          end
        end
        StActive: begin
          if (!frame_start && frame_active_q && !frame_active) begin
            state_q <= StDrain;
            drain_q <= DrainLoad;
          end
        end
        StDrain: begin
          if (frame_start) begin
            state_q <= StActive;
            drain_q <= 3'd0;
          end else if (drain_q <= 3'd1) begin
            state_q <= StIdle;
            drain_q <= 3'd0;
            idle_q  <= 1'b1;
          end else begin
            drain_q <= drain_q - 3'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          drain_q <= 3'd0;
          idle_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_read_scheduler.sv
// Self-checking bench for wave_read_scheduler: directed steps plus random traffic against a
// timestamp-based reference model of reads, bank latching and frame idle.
module tb_wave_read_scheduler;

  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int NS  = 640;
  localparam int LAT = 2;
  localparam int MEMSZ = 4096;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          read_index = 1'b0;
  logic          frame_start = 1'b0;
  logic          frame_active = 1'b0;
  logic          disp_req = 1'b0;
  logic          aux_req = 1'b0;
  logic [AW-2:0] disp_index = '0;
  logic [AW-2:0] aux_index = '0;
  logic [DW-1:0] disp_data, aux_data, ram_read_data;
  logic          disp_data_valid, aux_gnt, aux_data_valid, wave_display_idle;
  logic [AW-1:0] ram_read_address;

  logic [DW-1:0] mem [MEMSZ];
  logic [DW-1:0] ram_pipe [LAT];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model state
  bit            bank_m = 1'b0;
  bit            in_frame = 1'b0;
  bit            fa_prev = 1'b0;
  bit            exp_gnt = 1'b0;
  int            idle_at = -1;
  logic [AW-1:0] addr_m = '0;
  logic [DW-1:0] hold_d = '0;
  logic [DW-1:0] hold_a = '0;
  bit            pv_d [16];
  bit            pv_a [16];
  logic [DW-1:0] pd [16];

  wave_read_scheduler #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .SAMPLES    (NS),
    .RAM_LATENCY(LAT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .read_index       (read_index),
    .frame_start      (frame_start),
    .frame_active     (frame_active),
    .disp_req         (disp_req),
    .disp_index       (disp_index),
    .disp_data        (disp_data),
    .disp_data_valid  (disp_data_valid),
    .aux_req          (aux_req),
    .aux_index        (aux_index),
    .aux_gnt          (aux_gnt),
    .aux_data         (aux_data),
    .aux_data_valid   (aux_data_valid),
    .ram_read_address (ram_read_address),
    .ram_read_data    (ram_read_data),
    .wave_display_idle(wave_display_idle)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM with LAT cycles from address to data
  always @(posedge clk) begin
    ram_pipe[0] <= mem[ram_read_address];
    for (int i = 1; i < LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign ram_read_data = ram_pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [AW-2:0] rnd_idx();
    logic [31:0] r;
    r = (($urandom % 8) == 0) ? $urandom_range(2047, 0) : $urandom_range(NS - 1, 0);
    return r[AW-2:0];
  endfunction

  // One clock: check the grant, advance the model, then check registered outputs.
  task automatic step();
    logic [AW-2:0] idx;
    bit            be;
    int            slot;
    int            n;
    #1;
    exp_gnt = !reset && aux_req && !disp_req;
`ifdef AUX_IDLE_ONLY_EN
    exp_gnt = exp_gnt && !in_frame;
`endif
    chk("aux_gnt", 32'(aux_gnt), 32'(exp_gnt));
    if (reset) begin
      bank_m = 1'b0; in_frame = 1'b0; idle_at = -1; fa_prev = 1'b0;
      addr_m = '0; hold_d = '0; hold_a = '0;
      for (int i = 0; i < 16; i++) begin pv_d[i] = 1'b0; pv_a[i] = 1'b0; end
    end else begin
      be = frame_start ? read_index : bank_m;
      bank_m = be;
      if (disp_req || exp_gnt) begin
        idx    = disp_req ? disp_index : aux_index;
        addr_m = {be, idx};
        slot   = (cyc + 1 + LAT) % 16;
        pv_d[slot] = disp_req;
        pv_a[slot] = !disp_req;
        pd[slot]   = (int'(idx) >= NS) ? 8'h80 : mem[addr_m];
      end
      if (frame_start) begin
        in_frame = 1'b1;
        idle_at  = -1;
      end else if (in_frame && idle_at < 0 && fa_prev && !frame_active) begin
        idle_at = cyc + 2 + LAT;
      end
      fa_prev = frame_active;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (idle_at == cyc) begin
      in_frame = 1'b0;
      idle_at  = -1;
    end
    n = cyc % 16;
    if (pv_d[n]) hold_d = pd[n];
    if (pv_a[n]) hold_a = pd[n];
    chk("ram_read_address", 32'(ram_read_address), 32'(addr_m));
    chk("disp_data_valid", 32'(disp_data_valid), 32'(pv_d[n]));
    chk("aux_data_valid", 32'(aux_data_valid), 32'(pv_a[n]));
    chk("disp_data", 32'(disp_data), 32'(hold_d));
    chk("aux_data", 32'(aux_data), 32'(hold_a));
    chk("wave_display_idle", 32'(wave_display_idle), 32'(!in_frame));
    pv_d[n] = 1'b0;
    pv_a[n] = 1'b0;
    if (exp_gnt) aux_req = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
    mem[5] = 8'h40;

    // Reset
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_idle", 32'(wave_display_idle), 32'd1);
    chk("rst_addr", 32'(ram_read_address), 32'd0);
    chk("rst_disp_data", 32'(disp_data), 32'd0);

    // Basic display read from bank 0
    frame_start = 1'b1; frame_active = 1'b1; read_index = 1'b0;
    step();
    chk("t1_idle_drop", 32'(wave_display_idle), 32'd0);
    frame_start = 1'b0; disp_req = 1'b1; disp_index = 11'd5;
    step();
    chk("t1_addr", 32'(ram_read_address), 32'h005);
    disp_req = 1'b0;
    repeat (LAT) step();
    chk("t1_valid", 32'(disp_data_valid), 32'd1);
    chk("t1_data", 32'(disp_data), 32'h40);

    // Bank latch with same-cycle bypass, held across read_index changes
    read_index = 1'b1; frame_start = 1'b1; disp_req = 1'b1; disp_index = 11'd10;
    step();
    chk("t2_addr_bypass", 32'(ram_read_address), 32'h80A);
    frame_start = 1'b0; read_index = 1'b0;
    repeat (3) step();
    chk("t2_addr_held", 32'(ram_read_address), 32'h80A);
    frame_start = 1'b1;
    step();
    chk("t2_addr_newframe", 32'(ram_read_address), 32'h00A);
    frame_start = 1'b0;

    // Display priority over aux
    disp_index = 11'd20; aux_req = 1'b1; aux_index = 11'd7;
    repeat (3) step();
    disp_req = 1'b0;
    repeat (LAT + 3) step();

    // Drain timing: idle rises on the 4th cycle after frame_active falls
    frame_start = 1'b1; frame_active = 1'b1;
    step();
    frame_start = 1'b0;
    repeat (2) step();
    frame_active = 1'b0;
    repeat (3) begin
      step();
      chk("t4_drain_busy", 32'(wave_display_idle), 32'd0);
    end
    step();
    chk("t4_drain_idle", 32'(wave_display_idle), 32'd1);

    // frame_start during drain keeps the bank busy
    frame_start = 1'b1; frame_active = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    frame_active = 1'b0;
    repeat (2) step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    repeat (4) begin
      step();
      chk("t4_restart_busy", 32'(wave_display_idle), 32'd0);
    end
    frame_active = 1'b1;
    step();
    frame_active = 1'b0;
    repeat (6) step();

    // Out-of-range indices return midscale
    disp_req = 1'b1; disp_index = 11'd640;
    step();
    disp_index = 11'd2047;
    step();
    disp_req = 1'b0;
    repeat (LAT - 1) step();
    chk("t5_oob640_valid", 32'(disp_data_valid), 32'd1);
    chk("t5_oob640_data", 32'(disp_data), 32'h80);
    step();
    chk("t5_oob2047_valid", 32'(disp_data_valid), 32'd1);
    chk("t5_oob2047_data", 32'(disp_data), 32'h80);

    // Reset mid-flight flushes the pipeline
    disp_req = 1'b1; disp_index = 11'd3;
    step();
    disp_req = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (LAT + 1) begin
      step();
      chk("t7_flush_valid", 32'(disp_data_valid), 32'd0);
    end

    // Aux held through a frame
    frame_start = 1'b1; frame_active = 1'b1;
    step();
    frame_start = 1'b0; aux_req = 1'b1; aux_index = 11'd9;
    repeat (3) step();
    frame_active = 1'b0;
    repeat (8) step();

    // Random traffic
    for (int k = 0; k < 500; k++) begin
      disp_req    = ($urandom % 3) == 0;
      disp_index  = rnd_idx();
      frame_start = ($urandom % 40) == 0;
      read_index  = 1'($urandom % 2);
      if (($urandom % 12) == 0) frame_active = !frame_active;
      if (!aux_req) begin
        aux_req   = 1'($urandom % 2);
        aux_index = rnd_idx();
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
